// File: rtl/stoch_pkg.sv
// Shared types and constants for the stochastic core serial operand path.
// Used by the operand transmitter and the epoch counter.
package stoch_pkg;

  localparam int unsigned DATA_W     = 9;
  localparam int unsigned FRAME_BITS = DATA_W + 1;
  localparam int unsigned EPOCH_LEN  = 131073;

  localparam logic BUF_BIT = 1'b0;

  typedef logic [DATA_W-1:0] operand_t;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

endpackage

// File: rtl/stoch_epoch_counter.sv
// Free-running computation epoch counter, 0..LEN-1 with a wrap strobe.
// Shared between the operand transmitter and the result receiver.
module stoch_epoch_counter #(
  parameter  int unsigned LEN = 131073,
  localparam int unsigned W   = $clog2(LEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(LEN - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stoch_operand_tx.sv
// Serial operand transmitter: two lanes of 10-bit frames, LSB first.
// STOCH_TX_HOLD_EPOCH_EN defers operand updates to the first post-epoch frame.
module stoch_operand_tx #(
  parameter int unsigned EPOCH_LEN = stoch_pkg::EPOCH_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [stoch_pkg::DATA_W-1:0] op1_in,
  input  logic [stoch_pkg::DATA_W-1:0] op2_in,
  input  logic                        op_valid,
  output logic                        op_ready,
  output logic                        ser_out_1,
  output logic                        ser_out_2,
  output logic                        frame_start,
  output logic [3:0]                  bit_idx,
  output logic                        epoch_start,
  output logic                        active
);

  import stoch_pkg::*;

  localparam int unsigned CW = $clog2(EPOCH_LEN);

  tx_state_t state, state_nxt;

  operand_t cur1, cur2;
  operand_t pend1, pend2;
  logic     pending;
  logic [3:0] bit_q;

  logic [CW-1:0] epoch_cnt;
  logic          epoch_wrap;

  logic xfer;
  logic send;
  logic last_bit;
  logic apply_ok;
  logic boundary;

  assign op_ready = !pending;
  assign xfer     = op_valid && op_ready;
  assign send     = (state == SEND);
  assign last_bit = (bit_q == 4'(FRAME_BITS - 1));
  assign boundary = send && last_bit && apply_ok;
  assign bit_idx  = bit_q;

  stoch_epoch_counter #(
    .LEN (EPOCH_LEN)
  ) u_epoch (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (send),
    .clr   (!send && xfer),
    .cnt   (epoch_cnt),
    .wrap  (epoch_wrap)
  );

`ifdef STOCH_TX_HOLD_EPOCH_EN
  logic epoch_wrapped;

  // Armed by a wrap, consumed by the very next frame boundary.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      epoch_wrapped <= 1'b0;
    end else if (epoch_wrap) begin
      epoch_wrapped <= 1'b1;
    end else if (send && last_bit) begin
      epoch_wrapped <= 1'b0;
    end
  end

  assign apply_ok = epoch_wrapped;
`else
  logic epoch_wrap_unused;

  assign epoch_wrap_unused = epoch_wrap;
  assign apply_ok          = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ser_out_1   = 1'b0;
    ser_out_2   = 1'b0;
    frame_start = 1'b0;
    active      = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) state_nxt = SEND;
      end
      SEND: begin
        active      = 1'b1;
        frame_start = (bit_q == 4'd0);
        ser_out_1   = last_bit ? BUF_BIT : cur1[bit_q];
        ser_out_2   = last_bit ? BUF_BIT : cur2[bit_q];
      end
      default: ;
    endcase
  end

  assign epoch_start = active && (epoch_cnt == '0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cur1    <= '0;
      cur2    <= '0;
      pend1   <= '0;
      pend2   <= '0;
      pending <= 1'b0;
      bit_q   <= '0;
    end else if (!send) begin
      bit_q <= '0;
      if (xfer) begin
        cur1 <= op1_in;
        cur2 <= op2_in;
      end
    end else begin
      bit_q <= last_bit ? 4'd0 : bit_q + 4'd1;
      // Operands only ever change between frames.
      if (boundary && pending) begin
        cur1    <= pend1;
        cur2    <= pend2;
        pending <= 1'b0;
      end else if (boundary && xfer) begin
        cur1 <= op1_in;
        cur2 <= op2_in;
      end else if (xfer) begin
        pend1   <= op1_in;
        pend2   <= op2_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stoch_operand_tx.sv
// Randomised self-checking bench for stoch_operand_tx with a cycle-time model.
// Uses a short epoch so several full phase rotations fit in the run.
module tb_stoch_operand_tx;

  localparam int EL = 23;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] op1_in = '0;
  logic [8:0] op2_in = '0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic       ser_out_1;
  logic       ser_out_2;
  logic       frame_start;
  logic [3:0] bit_idx;
  logic       epoch_start;
  logic       active;

  int n_asrt = 0;
  int n_fail = 0;

  stoch_operand_tx #(
    .EPOCH_LEN (EL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op1_in      (op1_in),
    .op2_in      (op2_in),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .ser_out_1   (ser_out_1),
    .ser_out_2   (ser_out_2),
    .frame_start (frame_start),
    .bit_idx     (bit_idx),
    .epoch_start (epoch_start),
    .active      (active)
  );

  always #5 clk = ~clk;

  // Model: t is the cycle number since streaming began.
  bit         m_send;
  int         t;
  logic [8:0] m_cur1, m_cur2, m_pend1, m_pend2;
  bit         m_pending;

  function automatic bit may_apply(int tc);
`ifdef STOCH_TX_HOLD_EPOCH_EN
    int since;
    since = (tc + 1) % EL;
    return (tc >= EL) && (since >= 1) && (since <= 10);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_send = 0; t = 0; m_pending = 0;
    m_cur1 = '0; m_cur2 = '0; m_pend1 = '0; m_pend2 = '0;
  endtask

  task automatic model_edge();
    bit x, bnd;
    if (!m_send) begin
      if (op_valid) begin
        m_cur1 = op1_in; m_cur2 = op2_in; t = 0; m_send = 1;
      end
    end else begin
      x   = op_valid && !m_pending;
      bnd = (t % 10 == 9) && may_apply(t);
      if (bnd && m_pending) begin
        m_cur1 = m_pend1; m_cur2 = m_pend2; m_pending = 0;
      end else if (bnd && x) begin
        m_cur1 = op1_in; m_cur2 = op2_in;
      end else if (x) begin
        m_pend1 = op1_in; m_pend2 = op2_in; m_pending = 1;
      end
      t++;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int b;
    logic e1, e2;
    if (!m_send) begin
      chk("ser1", {31'd0, ser_out_1}, 0);
      chk("ser2", {31'd0, ser_out_2}, 0);
      chk("fstart", {31'd0, frame_start}, 0);
      chk("bit_idx", {28'd0, bit_idx}, 0);
      chk("estart", {31'd0, epoch_start}, 0);
      chk("active", {31'd0, active}, 0);
      chk("ready", {31'd0, op_ready}, 1);
    end else begin
      b  = t % 10;
      e1 = (b == 9) ? 1'b0 : m_cur1[b];
      e2 = (b == 9) ? 1'b0 : m_cur2[b];
      chk("ser1", {31'd0, ser_out_1}, {31'd0, e1});
      chk("ser2", {31'd0, ser_out_2}, {31'd0, e2});
      chk("fstart", {31'd0, frame_start}, (b == 0) ? 1 : 0);
      chk("bit_idx", {28'd0, bit_idx}, b);
      chk("estart", {31'd0, epoch_start}, (t % EL == 0) ? 1 : 0);
      chk("active", {31'd0, active}, 1);
      chk("ready", {31'd0, op_ready}, m_pending ? 0 : 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_bit(int b, string tag);
    int n;
    n = 0;
    while (!(m_send && t % 10 == b && !m_pending) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, (n < 100) ? 1 : 0, 1);
  endtask

  initial begin
    bit l1 [10];
    bit l2 [10];
    int k;
    l1 = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    l2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    model_reset();

    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (50) tick();

    op1_in = 9'h155; op2_in = 9'h0F0; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("lane1_pat", {31'd0, ser_out_1}, {31'd0, l1[i % 10]});
      chk("lane2_pat", {31'd0, ser_out_2}, {31'd0, l2[i % 10]});
      tick();
    end

    wait_bit(4, "mid_accept");
    op1_in = 9'h1FF; op2_in = 9'h1FF; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("mid_ready_drop", {31'd0, op_ready}, 0);
    repeat (25) tick();

    wait_bit(9, "bnd_accept");
    op1_in = 9'h0A3; op2_in = 9'h13C; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
`ifndef STOCH_TX_HOLD_EPOCH_EN
    chk("bnd_no_pending", {31'd0, op_ready}, 1);
    chk("bnd_new_bit0", {31'd0, ser_out_1}, 1);
`endif
    repeat (12) tick();

    for (int i = 0; i < 300; i++) begin
      op_valid = ($urandom_range(0, 3) == 0);
      op1_in   = 9'($urandom);
      op2_in   = 9'($urandom);
      tick();
      if (m_send && t % EL == 0) begin
        k = t / EL;
        chk("epoch_phase", {28'd0, bit_idx}, (3 * k) % 10);
      end
    end
    op_valid = 1'b0;

    wait_bit(4, "rst_setup");
    op1_in = 9'h0FF; op2_in = 9'h100; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("rst_pending", {31'd0, op_ready}, 0);
    rst_n = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (4) tick();
    op1_in = 9'h001; op2_in = 9'h002; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("restart_bit0", {28'd0, bit_idx}, 0);
    chk("restart_fstart", {31'd0, frame_start}, 1);
    chk("restart_ser1", {31'd0, ser_out_1}, 1);
    chk("restart_ser2", {31'd0, ser_out_2}, 0);
    repeat (25) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/stoch_operand_tx.md
Name: stoch_operand_tx

Overview:
Host-side transmitter for the stochastic core's serial operand interface. It accepts two 9-bit bipolar operands through a valid/ready handshake. It then streams them continuously as back-to-back 10-bit frames on two serial lines: 9 data bits LSB-first, then one buffer bit of 0. It also tracks the 2^17+1-cycle computation epoch, so the bench or host can correlate frames with result windows.

Parameters:
DATA_W, 9, operand width in bits.
FRAME_BITS, 10, bits per frame: DATA_W data bits plus 1 buffer bit. Must equal DATA_W+1.
EPOCH_LEN, 131073, cycles per computation epoch (2^17+1).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
op1_in  in  9  operand for serial lane 1
op2_in  in  9  operand for serial lane 2
op_valid  in  1  operand pair valid
op_ready  out  1  transmitter can accept a pair
ser_out_1  out  1  serial frame stream, lane 1
ser_out_2  out  1  serial frame stream, lane 2
frame_start  out  1  high while bit 0 of a frame is on the lines
bit_idx  out  4  current bit position, 0..9
epoch_start  out  1  high on cycle 0 of each epoch
active  out  1  streaming since first accepted pair

Behaviour:
- Reset: applies immediately and asynchronously, including mid-frame.
  - Clears cur_op1/2, pend_op1/2, pending, bit_idx and epoch_cnt to 0.
  - Returns state to IDLE.
  - Output values during and after reset: ser_out_1/2=0, frame_start=0, epoch_start=0, active=0, op_ready=1, bit_idx=0.
- Handshake:
  - Transfer occurs on a clock edge where op_valid && op_ready.
  - op_ready = !pending, a combinational decode of registers.
  - op_valid may be held high; each accepting edge consumes one pair.
- State IDLE:
  - Lines are held at 0.
  - On transfer: cur_op <= inputs, bit_idx <= 0, epoch_cnt <= 0, go to SEND.
  - Latency: bit 0 of the new frame is on the lines in the cycle after the accepting edge.
- State SEND:
  - ser_out_x = (bit_idx==9) ? 0 : cur_op_x[bit_idx].
  - frame_start = (bit_idx==0).
  - active = 1.
  - bit_idx increments each cycle and wraps 9 -> 0; frames repeat indefinitely with no gap.
- Operand update in SEND:
  - A transfer loads pend_op and sets pending.
  - At a frame-boundary edge (bit_idx==9): if pending, cur_op <= pend_op and pending is cleared.
  - Simultaneous transfer at the boundary edge (pending is 0 there by definition) bypasses pend_op and loads cur_op directly.
  - Result: an operand change never occurs mid-frame.
- Epoch counter:
  - epoch_cnt counts 0..EPOCH_LEN-1 in SEND and wraps to 0.
  - epoch_start = active && epoch_cnt==0.
  - Because 131073 mod 10 = 3, the frame phase at epoch start advances by 3 per epoch and repeats every 10 epochs. The receiver's alignment table depends on this sequence; it is a required property, not an artefact.
- No return to IDLE except via reset.

Optional Feature:
STOCH_TX_HOLD_EPOCH_EN
- Defined:
  - A pending pair is applied only at the first frame boundary after an epoch wrap.
  - An internal epoch_wrapped flag is set when epoch_cnt wraps and cleared when the pair is applied.
  - The boundary-bypass load is also restricted to that boundary.
  - This keeps operands constant across a full computation epoch.
- Undefined: the pair is applied at the next frame boundary, as described above.

Decomposition:
- Shared package stoch_pkg:
  - DATA_W, FRAME_BITS, EPOCH_LEN.
  - BUF_BIT = 1'b0.
  - typedef operand_t (logic [DATA_W-1:0]).
  - typedef enum tx_state_t {IDLE, SEND}.
- One sub-module stoch_epoch_counter (clk, rst_n, en, clr, cnt, wrap). It is reused later by the result receiver.
- Lane muxing stays inline.

Test Plan:
- Reset, no handshake for 50 cycles -> ser_out_1/2=0, active=0, op_ready=1, bit_idx=0 throughout.
- Accept op1=9'h155, op2=9'h0F0 at edge T -> from T+1, lane 1 shows 1,0,1,0,1,0,1,0,1,0 and lane 2 shows 0,0,0,0,1,1,1,1,0,0, repeating every 10 cycles; frame_start pulses every 10 cycles.
- While streaming 9'h155, accept 9'h1FF at bit_idx=4 -> op_ready drops; the current frame completes unchanged; the next frame is all-ones data with buffer bit 0; op_ready returns 1 after the boundary edge.
- Accept issued exactly at bit_idx=9 -> the next frame carries the new value; pending is never set.
- Run 10 epochs -> epoch_start asserts every 131073 cycles; bit_idx at epoch_start follows 0,3,6,9,2,5,8,1,4,7 (phase +3 per epoch), then repeats.
- Assert rst_n at bit_idx=5 with pending=1 -> all outputs reset at once; the pending pair is discarded; a new accept restarts at bit 0.
- With STOCH_TX_HOLD_EPOCH_EN: a pair accepted mid-epoch appears only on the first frame after the next epoch_start.
